// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment scanner for a packed BCD HH.MM.SS time word.
// The time word is double-sampled, snapshotted once per frame when stable, then decoded per slot.
module time_display_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [19:0] time_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic        frame_start
);

    localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_L = CNT_W'(BLANK_CYC);
    localparam logic            POL     = (ACTIVE_LOW != 0);
    localparam logic [6:0]      SEG_DASH = 7'h40;

    logic [19:0]      s1_q, s2_q, frm_q;
    logic [19:0]      frm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       slot_q, slot_d;
    logic             fs_q, fs_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [5:0]       an_q, an_d;

    logic             tick;
    logic             last_slot;
    logic             stable;
    logic [3:0]       digit;
    logic [3:0]       digit_max;
    logic [6:0]       seg_log;
    logic [5:0]       an_log;
    logic             dp_log;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // ---- Stage 0: input synchroniser, scan divider, slot and frame snapshot ----
    always_comb begin
        tick      = (cnt_q == CNT_MAX);
        last_slot = (slot_q == 3'd5);
        stable    = (s1_q == s2_q);

        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        slot_d = slot_q;
        if (tick) begin
            slot_d = last_slot ? 3'd0 : slot_q + 3'd1;
        end

        // An unstable word at the frame boundary keeps the previous time for one more frame.
        frm_d = (tick && last_slot && stable) ? s2_q : frm_q;
        fs_d  = tick && last_slot;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            frm_q  <= '0;
            cnt_q  <= '0;
            slot_q <= '0;
            fs_q   <= 1'b0;
        end else begin
            s1_q   <= time_in;
            s2_q   <= s1_q;
            frm_q  <= frm_d;
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            fs_q   <= fs_d;
        end
    end

    // ---- Stage 1: field select, range check and segment decode ----
    always_comb begin
        digit     = 4'd0;
        digit_max = 4'd9;
        case (slot_q)
            3'd0: begin digit = {2'b00, frm_q[19:18]}; digit_max = 4'd2; end
            3'd1: begin digit = frm_q[17:14];          digit_max = 4'd9; end
            3'd2: begin digit = {1'b0, frm_q[13:11]};  digit_max = 4'd5; end
            3'd3: begin digit = frm_q[10:7];           digit_max = 4'd9; end
            3'd4: begin digit = {1'b0, frm_q[6:4]};    digit_max = 4'd5; end
            3'd5: begin digit = frm_q[3:0];            digit_max = 4'd9; end
            default: begin digit = 4'd0;               digit_max = 4'd9; end
        endcase

        seg_log = (digit > digit_max) ? SEG_DASH : seg7(digit);
        if ((slot_q == 3'd0) && blank_lz && (digit == 4'd0)) begin
            seg_log = 7'h00;
        end

        // Anti-ghost gap: every digit is dark for the first BLANK_CYC cycles of a slot.
        an_log = (cnt_q < BLANK_L) ? 6'b000000 : (6'b100000 >> slot_q);
        dp_log = ((slot_q == 3'd1) || (slot_q == 3'd3)) && frm_q[0];

        seg_d = seg_log ^ {7{POL}};
        dp_d  = dp_log ^ POL;
        an_d  = an_log ^ {6{POL}};
    end

    // ---- Stage 2: registered pin drivers ----
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            seg_q <= {7{POL}};
            dp_q  <= POL;
            an_q  <= {6{POL}};
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan: a cycle-indexed reference model queues the expected
// pin values, a monitor compares both an active-high and an active-low instance every cycle.
module tb_time_display_scan;

    localparam int SD    = 8;
    localparam int BC    = 1;
    localparam int FRAME = 6 * SD;

    logic        clk;
    logic        rst;
    logic [19:0] time_in;
    logic        blank_lz;
    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [5:0]  an_h, an_l;
    logic        fs_h, fs_l;

    time_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(0)) u_dut (
        .clk_sys(clk), .rst(rst), .time_in(time_in), .blank_lz(blank_lz),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_start(fs_h)
    );

    time_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) u_inv (
        .clk_sys(clk), .rst(rst), .time_in(time_in), .blank_lz(blank_lz),
        .seg(seg_l), .dp(dp_l), .an(an_l), .frame_start(fs_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] an;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model state: edges since reset, snapshot, last two sampled words.
    int          j;
    logic [19:0] frm_m, h1, h2;

    const logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    const int DIG_MAX [6] = '{2, 9, 5, 9, 5, 9};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t, edge %0d)", name, act, req, $time, j);
        end
    endtask

    function automatic logic [19:0] pack(input int hh, input int hl, input int mh,
                                         input int ml, input int sh, input int sl);
        logic [1:0] a;
        logic [3:0] b, d, f;
        logic [2:0] c, e;
        a = hh[1:0]; b = hl[3:0]; c = mh[2:0]; d = ml[3:0]; e = sh[2:0]; f = sl[3:0];
        return {a, b, c, d, e, f};
    endfunction

    function automatic exp_t model_out(input int slot, input int cnt,
                                       input logic [19:0] fw, input logic blz, input logic fs);
        exp_t r;
        int   v;
        case (slot)
            0: v = int'(fw[19:18]);
            1: v = int'(fw[17:14]);
            2: v = int'(fw[13:11]);
            3: v = int'(fw[10:7]);
            4: v = int'(fw[6:4]);
            default: v = int'(fw[3:0]);
        endcase
        r.seg = (v > DIG_MAX[slot]) ? 7'h40 : SEG_TBL[v];
        if (slot == 0 && blz && v == 0) r.seg = 7'h00;
        r.dp = (slot == 1 || slot == 3) && fw[0];
        r.an = (cnt < BC) ? 6'd0 : 6'(1 << (5 - slot));
        r.fs = fs;
        return r;
    endfunction

    // Model: on each edge, the registered outputs reflect the state before that edge.
    initial begin
        j = 0; frm_m = '0; h1 = '0; h2 = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                j = 0; frm_m = '0; h1 = '0; h2 = '0;
                exp_q.delete();
            end else begin
                exp_q.push_back(model_out((j / SD) % 6, j % SD, frm_m, blank_lz,
                                          (j % FRAME) == FRAME - 1));
                if ((j % FRAME) == FRAME - 1 && h1 == h2) frm_m = h2;
                h2 = h1;
                h1 = time_in;
                j++;
            end
        end
    end

    // Monitor: compare both instances at the falling edge.
    initial begin
        exp_t       e;
        logic [6:0] iseg;
        logic [5:0] ian;
        logic       idp;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg", 32'(seg_h), 32'(e.seg));
                chk("dp", 32'(dp_h), 32'(e.dp));
                chk("an", 32'(an_h), 32'(e.an));
                chk("frame_start", 32'(fs_h), 32'(e.fs));
                iseg = ~e.seg; ian = ~e.an; idp = ~e.dp;
                chk("seg_pin_lo", 32'(seg_l), 32'(iseg));
                chk("dp_pin_lo", 32'(dp_l), 32'(idp));
                chk("an_pin_lo", 32'(an_l), 32'(ian));
                chk("frame_start_lo", 32'(fs_l), 32'(e.fs));
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input string name, input int ph);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if ((j % FRAME) == ph) return;
            @(negedge clk);
        end
        n_chk++; n_err++;
        $display("FAIL %s: phase %0d not reached, required within %0d cycles", name, ph, 2 * FRAME);
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_seg"}, 32'(seg_h), 32'h00);
        chk({tag, "_dp"}, 32'(dp_h), 32'h0);
        chk({tag, "_an"}, 32'(an_h), 32'h00);
        chk({tag, "_fs"}, 32'(fs_h), 32'h0);
        chk({tag, "_seg_lo"}, 32'(seg_l), 32'h7F);
        chk({tag, "_dp_lo"}, 32'(dp_l), 32'h1);
        chk({tag, "_an_lo"}, 32'(an_l), 32'h3F);
        chk({tag, "_fs_lo"}, 32'(fs_l), 32'h0);
    endtask

    initial begin
        logic [19:0] ta, tb;
        rst = 1'b1; time_in = '0; blank_lz = 1'b0;
        run(3);
        #1 chk_reset_pins("reset");
        @(negedge clk);
        rst = 1'b0;

        // 12:34:56, leading zero not blanked.
        time_in = pack(1, 2, 3, 4, 5, 6);
        run(3 * FRAME);

        // 09:05:07 with and without leading blank, then an even second.
        time_in = pack(0, 9, 0, 5, 0, 7);
        blank_lz = 1'b1;
        run(2 * FRAME);
        blank_lz = 1'b0;
        run(2 * FRAME);
        time_in = pack(0, 9, 0, 5, 0, 6);
        run(2 * FRAME);

        // Invalid fields one at a time.
        time_in = pack(1, 10, 3, 4, 5, 6);
        run(2 * FRAME);
        time_in = pack(3, 2, 3, 4, 5, 6);
        run(2 * FRAME);
        time_in = pack(1, 2, 6, 4, 5, 6);
        run(2 * FRAME);

        // Change mid-frame at slot 2: held until the next frame.
        wait_phase("slot2_wait", 2 * SD + 3);
        time_in = pack(2, 3, 5, 9, 5, 9);
        run(2 * FRAME);

        // Toggle every cycle across the snapshot edge: old time kept for a frame.
        ta = pack(1, 1, 1, 1, 1, 1);
        tb = pack(2, 2, 2, 2, 2, 2);
        wait_phase("toggle_wait", FRAME - 6);
        for (int k = 0; k < 10; k++) begin
            time_in = (k % 2 == 0) ? ta : tb;
            @(negedge clk);
        end
        run(2 * FRAME);

        // Randomised frames: valid and raw words, changes at random phases.
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 3) == 0)
                time_in = 20'($urandom);
            else
                time_in = pack($urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 5),
                               $urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9));
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    time_in = time_in ^ 20'h00001;
                    @(negedge clk);
                end
            end
            run($urandom_range(FRAME / 2, 2 * FRAME));
        end

        // Asynchronous reset in the middle of slot 3.
        time_in = pack(1, 2, 3, 4, 5, 7);
        blank_lz = 1'b0;
        run(2 * FRAME);
        wait_phase("slot3_wait", 3 * SD + 4);
        #2 rst = 1'b1;
        #1 chk_reset_pins("midrst");
        run(2);
        rst = 1'b0;
        run(3 * FRAME);

        chk("checks_run", 32'(n_chk > 1000), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
